md5_round2_unwind: RTL and testbench

Sequential inverse of the MD5 round-2 step chain. Given the state after step 31 and the 512-bit message block, it undoes round-2 steps 31 down to 32−NSTEPS, one step per clock, and returns the earlier state. It sits beside the forward round pipeline and serves meet-in-the-middle search and self-check of the forward datapath. It reuses the same 32-bit adder, subtract and rotate arithmetic as the forward round.

---
 rtl/md5_round2_unwind.sv | 193 +++++++++++++++++++
 tb/tb_md5_round2_unwind.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_round2_unwind.sv
// Inverse of the MD5 round-2 step chain: starting from the state after step 31,
// undoes one round-2 step per clock down to step 32-NSTEPS and returns that earlier state.
module md5_round2_unwind #(
  parameter int unsigned NSTEPS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  a_in,
  input  logic [31:0]  b_in,
  input  logic [31:0]  c_in,
  input  logic [31:0]  d_in,
  input  logic [511:0] msg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  a_out,
  output logic [31:0]  b_out,
  output logic [31:0]  c_out,
  output logic [31:0]  d_out,
  output logic         busy
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned MSG_W  = 512;
  localparam int unsigned J_W    = 5;

  localparam logic [J_W-1:0] FIRST_J = J_W'(31);
  localparam logic [J_W-1:0] LAST_J  = J_W'(32 - NSTEPS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Round-2 message word index k = (5j+1) mod 16; only j mod 16 matters.
  function automatic logic [3:0] msg_index(input logic [3:0] j_lo);
    return {j_lo[1:0], 2'b00} + j_lo + 4'd1;
  endfunction

  function automatic logic [4:0] rot_amount(input logic [1:0] j_mod4);
    logic [4:0] s;
    case (j_mod4)
      2'd0:    s = 5'd5;
      2'd1:    s = 5'd9;
      2'd2:    s = 5'd14;
      default: s = 5'd20;
    endcase
    return s;
  endfunction

  // Additive constants T[16..31], indexed by j-16 (the low four bits of j).
  function automatic logic [WORD_W-1:0] step_const(input logic [3:0] j_lo);
    logic [WORD_W-1:0] t;
    case (j_lo)
      4'd0:    t = 32'hf61e2562;
      4'd1:    t = 32'hc040b340;
      4'd2:    t = 32'h265e5a51;
      4'd3:    t = 32'he9b6c7aa;
      4'd4:    t = 32'hd62f105d;
      4'd5:    t = 32'h02441453;
      4'd6:    t = 32'hd8a1e681;
      4'd7:    t = 32'he7d3fbc8;
      4'd8:    t = 32'h21e1cde6;
      4'd9:    t = 32'hc33707d6;
      4'd10:   t = 32'hf4d50d87;
      4'd11:   t = 32'h455a14ed;
      4'd12:   t = 32'ha9e3e905;
      4'd13:   t = 32'hfcefa3f8;
      4'd14:   t = 32'h676f02d9;
      default: t = 32'h8d2a4c8a;
    endcase
    return t;
  endfunction

  function automatic logic [WORD_W-1:0] g_fn(input logic [WORD_W-1:0] x,
                                             input logic [WORD_W-1:0] y,
                                             input logic [WORD_W-1:0] z);
    return (x & z) | (y & ~z);
  endfunction

  // Left shift by (-s mod 32) supplies the wrapped bits; s is never 0 here.
  function automatic logic [WORD_W-1:0] rotr32(input logic [WORD_W-1:0] x,
                                               input logic [4:0]        s);
    return (x >> s) | (x << (5'd0 - s));
  endfunction

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  a_q, a_d;
  logic [WORD_W-1:0]  b_q, b_d;
  logic [WORD_W-1:0]  c_q, c_d;
  logic [WORD_W-1:0]  d_q, d_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [J_W-1:0]     j_q, j_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [3:0]         step_k;
  logic [WORD_W-1:0]  x_word;
  logic [WORD_W-1:0]  a_prev;

  // One inverse step on the working registers for the current j.
  always_comb begin
    step_k = msg_index(j_q[3:0]);
    x_word = msg_q[{step_k, 5'd0} +: WORD_W];
    a_prev = rotr32(b_q - c_q, rot_amount(j_q[1:0]))
             - g_fn(c_q, d_q, a_q) - x_word - step_const(j_q[3:0]);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    msg_d   = msg_q;
    j_d     = j_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          c_d     = c_in;
          d_d     = d_in;
          msg_d   = msg;
          j_d     = FIRST_J;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d = a_prev;
        b_d = c_q;
        c_d = d_q;
        d_d = a_q;
        j_d = j_q - J_W'(1);
        if (j_q == LAST_J) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake flags are registered copies of the next-state decode.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      msg_q       <= '0;
      j_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      msg_q       <= msg_d;
      j_q         <= j_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign c_out     = c_q;
  assign d_out     = d_q;

endmodule

// File: tb/tb_md5_round2_unwind.sv
// Self-checking bench for md5_round2_unwind: forward-round reference model, vector table,
// random full-round inversion, backpressure, mid-run reset and back-to-back traffic.
module tb_md5_round2_unwind;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } state_t;

  typedef struct {
    state_t       in_s;
    logic [511:0] m;
    state_t       exp_s;
  } vec_t;

  localparam logic [31:0] T_TAB [16] = '{
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a};
  localparam int S_TAB [4] = '{5, 9, 14, 20};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         iv = 1'b0;
  logic         or_r = 1'b0;
  logic         sel = 1'b0;
  logic [31:0]  a_in = '0, b_in = '0, c_in = '0, d_in = '0;
  logic [511:0] msg = '0;

  logic         in_valid0, in_ready0, out_valid0, busy0;
  logic [31:0]  a_out0, b_out0, c_out0, d_out0;
  logic         in_valid1, in_ready1, out_valid1, busy1;
  logic [31:0]  a_out1, b_out1, c_out1, d_out1;

  logic         ir_m, ov_m, busy_m;
  state_t       got_m;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign in_valid0 = iv & ~sel;
  assign in_valid1 = iv & sel;
  assign ir_m      = sel ? in_ready1  : in_ready0;
  assign ov_m      = sel ? out_valid1 : out_valid0;
  assign busy_m    = sel ? busy1      : busy0;
  assign got_m     = sel ? {a_out1, b_out1, c_out1, d_out1} : {a_out0, b_out0, c_out0, d_out0};

  md5_round2_unwind #(.NSTEPS(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in), .msg(msg),
    .out_valid(out_valid0), .out_ready(or_r),
    .a_out(a_out0), .b_out(b_out0), .c_out(c_out0), .d_out(d_out0), .busy(busy0));

  md5_round2_unwind #(.NSTEPS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in), .msg(msg),
    .out_valid(out_valid1), .out_ready(or_r),
    .a_out(a_out1), .b_out(b_out1), .c_out(c_out1), .d_out(d_out1), .busy(busy1));

  function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  function automatic logic [31:0] word_of(input logic [511:0] m, input int j);
    int k;
    k = (5 * j + 1) % 16;
    return m[32*k +: 32];
  endfunction

  // Forward MD5 round-2 steps first_j..31.
  function automatic state_t fwd(input state_t s0, input logic [511:0] m, input int first_j);
    logic [31:0] a, b, c, d, f, nb;
    a = s0.a; b = s0.b; c = s0.c; d = s0.d;
    for (int j = first_j; j <= 31; j++) begin
      f  = (b & d) | (c & ~d);
      nb = b + rotl(a + f + word_of(m, j) + T_TAB[j-16], S_TAB[j%4]);
      a  = d; d = c; c = b; b = nb;
    end
    return '{a: a, b: b, c: c, d: d};
  endfunction

  // Inverse round 2 from step 31 down to last_j, straight from the step equations.
  function automatic state_t inv(input state_t s31, input logic [511:0] m, input int last_j);
    logic [31:0] a, b, c, d, f, pa;
    a = s31.a; b = s31.b; c = s31.c; d = s31.d;
    for (int j = 31; j >= last_j; j--) begin
      f  = (c & a) | (d & ~a);
      pa = rotr(b - c, S_TAB[j%4]) - f - word_of(m, j) - T_TAB[j-16];
      b = c; c = d; d = a; a = pa;
    end
    return '{a: a, b: b, c: c, d: d};
  endfunction

  function automatic logic [511:0] rand_msg();
    logic [511:0] m;
    for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
    return m;
  endfunction

  function automatic state_t rand_state();
    return '{a: $urandom, b: $urandom, c: $urandom, d: $urandom};
  endfunction

  task automatic check_st(input string name, input state_t got, input state_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h_%h_%h_%h want %h_%h_%h_%h", name,
               got.a, got.b, got.c, got.d, exp.a, exp.b, exp.c, exp.d);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    a_in = v.in_s.a; b_in = v.in_s.b; c_in = v.in_s.c; d_in = v.in_s.d;
    msg  = v.m;
  endtask

  task automatic scramble();
    a_in = $urandom; b_in = $urandom; c_in = $urandom; d_in = $urandom;
    msg  = rand_msg();
  endtask

  // Waits (bounded) for out_valid, checks latency and data, then pops the result.
  task automatic wait_result(input string name, input state_t exp, input int edges0,
                             input int exp_lat);
    int edges;
    edges = edges0;
    while (!ov_m && edges < 100) begin
      tick();
      edges++;
    end
    check_int({name, " latency"}, edges, exp_lat);
    check_st(name, got_m, exp);
    or_r = 1'b1;
    tick();
    or_r = 1'b0;
    check_int({name, " idle"}, int'(ir_m), 1);
  endtask

  task automatic run_vec(input string name, input vec_t v, input int exp_lat);
    drive(v);
    iv = 1'b1;
    tick();
    iv = 1'b0;
    scramble();
    wait_result(name, v.exp_s, 1, exp_lat);
  endtask

  function automatic vec_t mk_fwd(input state_t orig, input logic [511:0] m, input int first_j);
    vec_t v;
    v.in_s  = fwd(orig, m, first_j);
    v.m     = m;
    v.exp_s = orig;
    return v;
  endfunction

  initial begin
    vec_t   tbl[8];
    vec_t   v, vb;
    vec_t   bb[4];
    state_t zero_s, ones_s;
    logic [511:0] ones_m;
    int     idx, got_n, last_cyc, ncyc;
    logic   accept_now;

    zero_s = '0;
    ones_s = '1;
    ones_m = '1;

    tbl[0] = mk_fwd('{a: 32'h67452301, b: 32'hefcdab89, c: 32'h98badcfe, d: 32'h10325476},
                    rand_msg(), 16);
    tbl[1] = mk_fwd(zero_s, '0, 16);
    tbl[2].in_s = ones_s; tbl[2].m = ones_m; tbl[2].exp_s = inv(ones_s, ones_m, 16);
    tbl[3] = mk_fwd(ones_s, ones_m, 16);
    for (int i = 4; i < 8; i++) tbl[i] = mk_fwd(rand_state(), rand_msg(), 16);

    // Asynchronous reset, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    check_int("reset in_ready", int'(in_ready0), 1);
    check_int("reset out_valid", int'(out_valid0), 0);
    check_int("reset busy", int'(busy0), 0);
    check_st("reset outputs", {a_out0, b_out0, c_out0, d_out0}, zero_s);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // NSTEPS=1 instance: known single-step vector, then a few random ones.
    sel = 1'b1;
    v.in_s = '{a: 32'h0, b: 32'hc8a8d2a4, c: 32'h0, d: 32'h0};
    v.m = '0;
    v.exp_s = zero_s;
    run_vec("single step", v, 2);
    for (int i = 0; i < 4; i++) run_vec("single step rand", mk_fwd(rand_state(), rand_msg(), 31), 2);
    sel = 1'b0;

    for (int i = 0; i < 8; i++) run_vec($sformatf("table[%0d]", i), tbl[i], 17);

    for (int i = 0; i < 1000; i++) begin
      v = mk_fwd(rand_state(), rand_msg(), 16);
      run_vec("random full round", v, 17);
    end

    // Backpressure: hold DONE for 20 cycles while a second request is offered.
    v  = mk_fwd(rand_state(), rand_msg(), 16);
    vb = mk_fwd(rand_state(), rand_msg(), 16);
    drive(v);
    iv = 1'b1;
    tick();
    iv = 1'b0;
    scramble();
    ncyc = 1;
    while (!out_valid0 && ncyc < 100) begin
      tick();
      ncyc++;
    end
    check_int("bp latency", ncyc, 17);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        drive(vb);
        iv = 1'b1;
      end
      check_st("bp hold data", got_m, v.exp_s);
      check_int("bp hold valid", int'(out_valid0), 1);
      check_int("bp hold in_ready", int'(in_ready0), 0);
      tick();
    end
    or_r = 1'b1;
    tick();
    or_r = 1'b0;
    check_int("bp release in_ready", int'(in_ready0), 1);
    check_int("bp release out_valid", int'(out_valid0), 0);
    tick();
    iv = 1'b0;
    scramble();
    check_int("bp second accept busy", int'(busy0), 1);
    check_int("bp second accept in_ready", int'(in_ready0), 0);
    wait_result("bp second block", vb.exp_s, 1, 17);

    // Reset in the middle of RUN, observed without a clock edge.
    v = mk_fwd(rand_state(), rand_msg(), 16);
    drive(v);
    iv = 1'b1;
    tick();
    iv = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    #2 rst = 1'b1;
    #1;
    check_st("midrun reset outputs", {a_out0, b_out0, c_out0, d_out0}, zero_s);
    check_int("midrun reset in_ready", int'(in_ready0), 1);
    check_int("midrun reset out_valid", int'(out_valid0), 0);
    check_int("midrun reset busy", int'(busy0), 0);
    #2 rst = 1'b0;
    tick();
    run_vec("after reset", mk_fwd(rand_state(), rand_msg(), 16), 17);

    // Back-to-back with in_valid held high and out_ready held at 1.
    for (int i = 0; i < 4; i++) bb[i] = mk_fwd(rand_state(), rand_msg(), 16);
    idx = 0; got_n = 0; ncyc = 0; last_cyc = 0;
    or_r = 1'b1;
    drive(bb[0]);
    iv = 1'b1;
    while (got_n < 4 && ncyc < 200) begin
      accept_now = in_ready0 && iv;
      tick();
      ncyc++;
      if (accept_now) begin
        idx++;
        if (idx < 4) drive(bb[idx]);
        else iv = 1'b0;
      end
      if (out_valid0) begin
        check_st($sformatf("b2b result %0d", got_n), got_m, bb[got_n].exp_s);
        if (got_n > 0) check_int($sformatf("b2b spacing %0d", got_n), ncyc - last_cyc, 18);
        last_cyc = ncyc;
        got_n++;
      end
    end
    iv = 1'b0;
    or_r = 1'b0;
    check_int("b2b result count", got_n, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
